// File: rtl/pcie_tlp_pkg.sv
// Shared PCIe TLP decode definitions: fmt/type codes, header field positions, RX FSM states.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package pcie_tlp_pkg;

  localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
  localparam logic [1:0] FMT_4DW_NODATA = 2'b01;
  localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
  localparam logic [1:0] FMT_4DW_DATA   = 2'b11;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;

  // Header DW0 field positions
  localparam int DW0_FMT_LSB  = 29;
  localparam int DW0_TYPE_LSB = 24;
  localparam int DW0_TC_LSB   = 20;
  localparam int DW0_EP_BIT   = 14;
  localparam int DW0_ATTR_LSB = 12;
  localparam int DW0_LEN_LSB  = 0;

  // Header DW1 field positions
  localparam int DW1_REQID_LSB = 16;
  localparam int DW1_TAG_LSB   = 8;
  localparam int DW1_LBE_LSB   = 4;
  localparam int DW1_FBE_LSB   = 0;

  // bar_hit location in the bridge tuser sideband
  localparam int TUSER_BAR_LSB = 2;

  typedef enum logic [2:0] {
    ST_HDR0     = 3'd0,
    ST_HDR1     = 3'd1,
    ST_HDR2     = 3'd2,
    ST_HDR3     = 3'd3,
    ST_WR_DATA  = 3'd4,
    ST_RD_ISSUE = 3'd5,
    ST_DISCARD  = 3'd6
  } rx_state_e;

  // A zero length field means the maximum of 1024 DW.
  function automatic logic [10:0] decode_len(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

endpackage

// File: rtl/pcie_rx_tlp_stats.sv
// Accepted/dropped TLP counters, updated once per TLP on its final accepted beat.
// Latency: counters reflect a TLP one cycle after its final beat.
// Backpressure: none; purely observes the decoder's end-of-TLP strobe.
// Ports: i_tlp_end (final beat accepted), i_tlp_drop (that TLP was dropped),
//        o_tlp_count (accepted TLPs, wraps), o_drop_count (dropped TLPs, wraps).
module pcie_rx_tlp_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_tlp_end,
  input  logic        i_tlp_drop,
  output logic [31:0] o_tlp_count,
  output logic [15:0] o_drop_count
);

  logic [31:0] r_tlp_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tlp_cnt  <= 32'd0;
      r_drop_cnt <= 16'd0;
    end else if (i_tlp_end) begin
      if (i_tlp_drop) r_drop_cnt <= r_drop_cnt + 16'd1;
      else            r_tlp_cnt  <= r_tlp_cnt + 32'd1;
    end
  end

  assign o_tlp_count  = r_tlp_cnt;
  assign o_drop_count = r_drop_cnt;

endmodule

// File: rtl/artemis_pcie_rx_tlp_decoder.sv
// Decodes 32-bit RX memory TLPs into a write-beat stream and a one-entry read descriptor.
// Latency: write beat 1 cycle after RX accept; read descriptor 1 cycle after last header DW.
// Backpressure: write path stalls RX while a held beat is not taken; RX stalls in RD_ISSUE.
// Ports: i_rx_* / o_rx_tready  AXI-Stream TLP input (bar_hit in tuser[8:2])
//        o_wr_* / i_wr_ready   write beats (addr, data, be, last)
//        o_rd_* / i_rd_req_ready read request descriptor; o_rx_np_ok = slot empty
//        o_bar_hit, o_unsup    latched bar_hit and per-dropped-TLP pulse
// Optional: define PCIE_RX_TLP_STATS_EN to add o_tlp_count / o_drop_count.
module artemis_pcie_rx_tlp_decoder
  import pcie_tlp_pkg::*;
#(
  parameter logic [6:0] BAR_MASK = 7'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_rx_tdata,
  input  logic [3:0]  i_rx_tkeep,
  input  logic        i_rx_tlast,
  input  logic        i_rx_tvalid,
  output logic        o_rx_tready,
  input  logic [21:0] i_rx_tuser,
  output logic        o_rx_np_ok,
  output logic        o_wr_valid,
  input  logic        i_wr_ready,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic [3:0]  o_wr_be,
  output logic        o_wr_last,
  output logic        o_rd_req_valid,
  input  logic        i_rd_req_ready,
  output logic [31:0] o_rd_addr,
  output logic [10:0] o_rd_len,
  output logic [7:0]  o_rd_tag,
  output logic [15:0] o_rd_req_id,
  output logic [3:0]  o_rd_first_be,
  output logic [3:0]  o_rd_last_be,
  output logic [2:0]  o_rd_tc,
  output logic [1:0]  o_rd_attr,
  output logic [6:0]  o_bar_hit,
  output logic        o_unsup
`ifdef PCIE_RX_TLP_STATS_EN
  ,
  output logic [31:0] o_tlp_count,
  output logic [15:0] o_drop_count
`endif
);

  rx_state_e   r_state, w_state_nxt;
  logic        r_out_en;
  logic [1:0]  r_fmt;
  logic [2:0]  r_tc;
  logic [1:0]  r_attr;
  logic [10:0] r_len;
  logic [6:0]  r_bar;
  logic [15:0] r_req_id;
  logic [7:0]  r_tag;
  logic [3:0]  r_lbe, r_fbe;
  logic [31:0] r_addr;
  logic [10:0] r_beat;
  logic        r_wr_vld, r_wr_last, r_rd_vld, r_unsup;
  logic [31:0] r_wr_addr, r_wr_dat;
  logic [3:0]  r_wr_be;

  logic        w_rdy, w_acc;
  logic        w_unsup_evt, w_wr_beat, w_rd_start, w_addr_cap, w_last_hdr;
  logic [1:0]  w_d0_fmt;
  logic [6:0]  w_d0_bar;
  logic        w_d0_bad, w_is_4dw, w_is_wr;

  // tkeep is implied by the DW-granular protocol; other tuser bits are not used here.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, i_rx_tkeep, i_rx_tuser[21:9], i_rx_tuser[1:0]};

  assign w_acc    = i_rx_tvalid && o_rx_tready;
  assign w_d0_fmt = i_rx_tdata[DW0_FMT_LSB +: 2];
  assign w_d0_bar = i_rx_tuser[TUSER_BAR_LSB +: 7];
  assign w_d0_bad = (i_rx_tdata[DW0_TYPE_LSB +: 5] != TYPE_MEM) ||
                    ((w_d0_bar & BAR_MASK) == 7'd0) ||
                    (i_rx_tdata[DW0_EP_BIT] &&
                     (w_d0_fmt == FMT_3DW_DATA || w_d0_fmt == FMT_4DW_DATA));
  assign w_is_4dw = (r_fmt == FMT_4DW_NODATA) || (r_fmt == FMT_4DW_DATA);
  assign w_is_wr  = (r_fmt == FMT_3DW_DATA)   || (r_fmt == FMT_4DW_DATA);

  always_comb begin
    w_rdy = 1'b0;
    case (r_state)
      ST_HDR0, ST_HDR1, ST_HDR2, ST_HDR3, ST_DISCARD: w_rdy = 1'b1;
      ST_WR_DATA:  w_rdy = !r_wr_vld || i_wr_ready;
      default:     w_rdy = 1'b0;
    endcase
  end

  // r_out_en keeps tready low while reset is held and for the first cycle after.
  assign o_rx_tready = r_out_en && w_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_HDR0;
      r_out_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_out_en <= 1'b1;
    end
  end

  // A drop detected on a beat that already carries tlast returns straight to
  // HDR0; otherwise the remainder of the TLP is drained in DISCARD.
  always_comb begin
    w_state_nxt = r_state;
    w_unsup_evt = 1'b0;
    w_wr_beat   = 1'b0;
    w_rd_start  = 1'b0;
    w_addr_cap  = 1'b0;
    w_last_hdr  = 1'b0;
    case (r_state)
      ST_HDR0: if (w_acc) begin
        if (w_d0_bad || i_rx_tlast) begin
          w_unsup_evt = 1'b1;
          w_state_nxt = i_rx_tlast ? ST_HDR0 : ST_DISCARD;
        end else begin
          w_state_nxt = ST_HDR1;
        end
      end
      ST_HDR1: if (w_acc) begin
        if (i_rx_tlast) begin
          w_unsup_evt = 1'b1;
          w_state_nxt = ST_HDR0;
        end else begin
          w_state_nxt = ST_HDR2;
        end
      end
      ST_HDR2: if (w_acc) begin
        if (w_is_4dw) begin
          if ((i_rx_tdata != 32'd0) || i_rx_tlast) begin
            w_unsup_evt = 1'b1;
            w_state_nxt = i_rx_tlast ? ST_HDR0 : ST_DISCARD;
          end else begin
            w_state_nxt = ST_HDR3;
          end
        end else begin
          w_last_hdr = 1'b1;
        end
      end
      ST_HDR3: if (w_acc) w_last_hdr = 1'b1;
      ST_WR_DATA: if (w_acc) begin
        w_wr_beat = 1'b1;
        if (i_rx_tlast) begin
          w_state_nxt = ST_HDR0;
          w_unsup_evt = (r_beat != r_len);
        end else if (r_beat == r_len) begin
          w_unsup_evt = 1'b1;
          w_state_nxt = ST_DISCARD;
        end
      end
      ST_RD_ISSUE: if (r_rd_vld && i_rd_req_ready) w_state_nxt = ST_HDR0;
      ST_DISCARD:  if (w_acc && i_rx_tlast) w_state_nxt = ST_HDR0;
      default:     w_state_nxt = ST_HDR0;
    endcase

    // Final header DW (HDR2 of a 3DW header, or HDR3): writes continue, reads end here.
    if (w_last_hdr) begin
      w_addr_cap = 1'b1;
      if (w_is_wr) begin
        w_unsup_evt = i_rx_tlast;
        w_state_nxt = i_rx_tlast ? ST_HDR0 : ST_WR_DATA;
      end else if (i_rx_tlast) begin
        w_rd_start  = 1'b1;
        w_state_nxt = ST_RD_ISSUE;
      end else begin
        w_unsup_evt = 1'b1;
        w_state_nxt = ST_DISCARD;
      end
    end
  end

  // Header capture and running address / beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fmt    <= 2'd0;
      r_tc     <= 3'd0;
      r_attr   <= 2'd0;
      r_len    <= 11'd0;
      r_bar    <= 7'd0;
      r_req_id <= 16'd0;
      r_tag    <= 8'd0;
      r_lbe    <= 4'd0;
      r_fbe    <= 4'd0;
      r_addr   <= 32'd0;
      r_beat   <= 11'd0;
    end else begin
      if (r_state == ST_HDR0 && w_acc) begin
        r_fmt  <= w_d0_fmt;
        r_tc   <= i_rx_tdata[DW0_TC_LSB +: 3];
        r_attr <= i_rx_tdata[DW0_ATTR_LSB +: 2];
        r_len  <= decode_len(i_rx_tdata[DW0_LEN_LSB +: 10]);
        r_bar  <= w_d0_bar;
      end
      if (r_state == ST_HDR1 && w_acc) begin
        r_req_id <= i_rx_tdata[DW1_REQID_LSB +: 16];
        r_tag    <= i_rx_tdata[DW1_TAG_LSB +: 8];
        r_lbe    <= i_rx_tdata[DW1_LBE_LSB +: 4];
        r_fbe    <= i_rx_tdata[DW1_FBE_LSB +: 4];
      end
      if (w_addr_cap) begin
        r_addr <= {i_rx_tdata[31:2], 2'b00};
        r_beat <= 11'd1;
      end else if (w_wr_beat) begin
        r_addr <= r_addr + 32'd4;
        r_beat <= r_beat + 11'd1;
      end
    end
  end

  // Registered write beat; holds until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_vld  <= 1'b0;
      r_wr_addr <= 32'd0;
      r_wr_dat  <= 32'd0;
      r_wr_be   <= 4'd0;
      r_wr_last <= 1'b0;
    end else if (w_wr_beat) begin
      r_wr_vld  <= 1'b1;
      r_wr_addr <= r_addr;
      r_wr_dat  <= i_rx_tdata;
      // first_be wins on beat 1, so a 1-DW write never uses last_be
      r_wr_be   <= (r_beat == 11'd1) ? r_fbe : ((r_beat == r_len) ? r_lbe : 4'hF);
      r_wr_last <= i_rx_tlast || (r_beat == r_len);
    end else if (i_wr_ready) begin
      r_wr_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
      r_unsup  <= 1'b0;
    end else begin
      r_unsup <= w_unsup_evt;
      if (w_rd_start)          r_rd_vld <= 1'b1;
      else if (i_rd_req_ready) r_rd_vld <= 1'b0;
    end
  end

  assign o_wr_valid     = r_wr_vld;
  assign o_wr_addr      = r_wr_addr;
  assign o_wr_data      = r_wr_dat;
  assign o_wr_be        = r_wr_be;
  assign o_wr_last      = r_wr_last;
  assign o_rd_req_valid = r_rd_vld;
  assign o_rx_np_ok     = !r_rd_vld;
  // Descriptor fields are stable in RD_ISSUE since RX is stalled there.
  assign o_rd_addr      = r_addr;
  assign o_rd_len       = r_len;
  assign o_rd_tag       = r_tag;
  assign o_rd_req_id    = r_req_id;
  assign o_rd_first_be  = r_fbe;
  assign o_rd_last_be   = r_lbe;
  assign o_rd_tc        = r_tc;
  assign o_rd_attr      = r_attr;
  assign o_bar_hit      = r_bar;
  assign o_unsup        = r_unsup;

`ifdef PCIE_RX_TLP_STATS_EN
  // Remembers that the TLP in flight was already flagged (e.g. long write).
  logic r_dropped;
  logic w_tlp_end;
  assign w_tlp_end = w_acc && i_rx_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_dropped <= 1'b0;
    else if (w_tlp_end)   r_dropped <= 1'b0;
    else if (w_unsup_evt) r_dropped <= 1'b1;
  end

  pcie_rx_tlp_stats u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tlp_end    (w_tlp_end),
    .i_tlp_drop   (w_unsup_evt || r_dropped),
    .o_tlp_count  (o_tlp_count),
    .o_drop_count (o_drop_count)
  );
`endif

endmodule

// File: tb/tb_artemis_pcie_rx_tlp_decoder.sv
module tb_artemis_pcie_rx_tlp_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_rx_tdata = '0;
  logic [3:0]  i_rx_tkeep = 4'hF;
  logic        i_rx_tlast = 1'b0;
  logic        i_rx_tvalid = 1'b0;
  logic        o_rx_tready;
  logic [21:0] i_rx_tuser = '0;
  logic        o_rx_np_ok;
  logic        o_wr_valid;
  logic        i_wr_ready = 1'b0;
  logic [31:0] o_wr_addr, o_wr_data;
  logic [3:0]  o_wr_be;
  logic        o_wr_last;
  logic        o_rd_req_valid;
  logic        i_rd_req_ready = 1'b0;
  logic [31:0] o_rd_addr;
  logic [10:0] o_rd_len;
  logic [7:0]  o_rd_tag;
  logic [15:0] o_rd_req_id;
  logic [3:0]  o_rd_first_be, o_rd_last_be;
  logic [2:0]  o_rd_tc;
  logic [1:0]  o_rd_attr;
  logic [6:0]  o_bar_hit;
  logic        o_unsup;
`ifdef PCIE_RX_TLP_STATS_EN
  logic [31:0] o_tlp_count;
  logic [15:0] o_drop_count;
`endif

  artemis_pcie_rx_tlp_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .i_rx_tdata(i_rx_tdata), .i_rx_tkeep(i_rx_tkeep), .i_rx_tlast(i_rx_tlast),
    .i_rx_tvalid(i_rx_tvalid), .o_rx_tready(o_rx_tready), .i_rx_tuser(i_rx_tuser),
    .o_rx_np_ok(o_rx_np_ok),
    .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_wr_be(o_wr_be), .o_wr_last(o_wr_last),
    .o_rd_req_valid(o_rd_req_valid), .i_rd_req_ready(i_rd_req_ready),
    .o_rd_addr(o_rd_addr), .o_rd_len(o_rd_len), .o_rd_tag(o_rd_tag),
    .o_rd_req_id(o_rd_req_id), .o_rd_first_be(o_rd_first_be), .o_rd_last_be(o_rd_last_be),
    .o_rd_tc(o_rd_tc), .o_rd_attr(o_rd_attr), .o_bar_hit(o_bar_hit), .o_unsup(o_unsup)
`ifdef PCIE_RX_TLP_STATS_EN
    , .o_tlp_count(o_tlp_count), .o_drop_count(o_drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct { logic [31:0] d; logic last; logic [6:0] bar; } beat_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] be; logic last; } wr_t;
  typedef struct {
    logic [31:0] addr; logic [10:0] len; logic [7:0] tag; logic [15:0] rid;
    logic [3:0] fbe; logic [3:0] lbe; logic [2:0] tc; logic [1:0] attr; logic [6:0] bar;
  } rd_t;

  beat_t txq[$];
  wr_t   exp_wr[$];
  rd_t   exp_rd[$];
  int    exp_unsup = 0;
  int    obs_unsup = 0;
  bit    drv_en = 1'b1;
  int    wr_mode = 0;   // 0: random ready, 1: toggle every cycle
  int    rd_pct = 40;
  int    vld_pct = 80;

  // Reference model: builds the TLP beats and predicts outputs from the TLP rules.
  // n is the total beat count; tlast sits on beat n. d0 != 0 gives data d0, d0+0x11, ...
  task automatic send_tlp(input logic [1:0] fmt, input logic [4:0] typ, input logic ep,
                          input logic [9:0] len, input logic [3:0] fbe, input logic [3:0] lbe,
                          input logic [7:0] tag, input logic [31:0] hi, input logic [31:0] lo,
                          input logic [6:0] bar, input int n, input logic [31:0] d0);
    logic [31:0] hdr[4];
    logic [31:0] dat[$];
    logic [15:0] rid;
    logic [2:0]  tc;
    logic [1:0]  attr;
    int hlen, l, k, nd;
    bit wr, drop;
    beat_t b;
    wr_t w;
    rd_t r;
    rid = 16'($urandom); tc = 3'($urandom); attr = 2'($urandom);
    wr = fmt[1];
    hlen = fmt[0] ? 4 : 3;
    l = (len == 10'd0) ? 1024 : int'(len);
    hdr[0] = {1'b0, fmt, typ, 1'b0, tc, 4'b0, 1'b0, ep, attr, 2'b0, len};
    hdr[1] = {rid, tag, lbe, fbe};
    hdr[2] = (hlen == 4) ? hi : lo;
    hdr[3] = lo;
    for (int i = 0; i < n; i++) begin
      b.d = (i < hlen) ? hdr[i] : ((d0 != 0) ? d0 + 32'h11 * (i - hlen) : $urandom);
      b.last = (i == n - 1);
      b.bar = bar;
      if (i >= hlen) dat.push_back(b.d);
      txq.push_back(b);
    end
    drop = ((bar & 7'h01) == 0) || (typ != 5'd0) || (wr && ep) || (hlen == 4 && hi != 0);
    if (wr) drop = drop || (n <= hlen);
    else    drop = drop || (n != hlen);
    if (drop) begin
      exp_unsup++;
    end else if (wr) begin
      nd = n - hlen;
      k = (nd < l) ? nd : l;
      for (int i = 1; i <= k; i++) begin
        w.addr = {lo[31:2], 2'b00} + 32'(4 * (i - 1));
        w.data = dat[i - 1];
        w.be   = (i == 1) ? fbe : ((i == l) ? lbe : 4'hF);
        w.last = (i == k);
        exp_wr.push_back(w);
      end
      if (nd != l) exp_unsup++;
    end else begin
      r.addr = {lo[31:2], 2'b00}; r.len = 11'(l); r.tag = tag; r.rid = rid;
      r.fbe = fbe; r.lbe = lbe; r.tc = tc; r.attr = attr; r.bar = bar;
      exp_rd.push_back(r);
    end
  endtask

  // Driver: presents queued beats with random gaps, holds a beat until accepted.
  initial begin
    bit hs, held;
    forever begin
      @(negedge clk);
      hs = i_rx_tvalid && o_rx_tready;
      @(posedge clk);
      #1;
      if (hs && txq.size() > 0) void'(txq.pop_front());
      held = i_rx_tvalid && !hs;
      if (!drv_en || !rst_n) begin
        i_rx_tvalid = 1'b0;
      end else if (txq.size() > 0 && (held || $urandom_range(99) < vld_pct)) begin
        i_rx_tvalid = 1'b1;
        i_rx_tdata  = txq[0].d;
        i_rx_tlast  = txq[0].last;
        i_rx_tuser  = {13'd0, txq[0].bar, 2'b00};
      end else begin
        i_rx_tvalid = 1'b0;
      end
      i_wr_ready     = (wr_mode == 1) ? ~i_wr_ready : ($urandom_range(99) < 60);
      i_rd_req_ready = ($urandom_range(99) < rd_pct);
    end
  end

  // Monitor / scoreboard
  initial begin
    wr_t w;
    rd_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_unsup) obs_unsup++;
        if (o_wr_valid && i_wr_ready) begin
          if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            w = exp_wr.pop_front();
            chk("wr_addr", o_wr_addr, w.addr);
            chk("wr_data", o_wr_data, w.data);
            chk("wr_be", o_wr_be, w.be);
            chk("wr_last", o_wr_last, w.last);
          end
        end
        if (o_rd_req_valid) begin
          chk("rd_tready_low", o_rx_tready, 0);
          chk("rd_np_ok_low", o_rx_np_ok, 0);
          if (i_rd_req_ready) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
              r = exp_rd.pop_front();
              chk("rd_addr", o_rd_addr, r.addr);
              chk("rd_len", o_rd_len, r.len);
              chk("rd_tag", o_rd_tag, r.tag);
              chk("rd_req_id", o_rd_req_id, r.rid);
              chk("rd_be", {o_rd_first_be, o_rd_last_be}, {r.fbe, r.lbe});
              chk("rd_tc_attr", {o_rd_tc, o_rd_attr}, {r.tc, r.attr});
              chk("rd_bar", o_bar_hit, r.bar);
            end
          end
        end
      end
    end
  end

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    while ((txq.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0 ||
            o_wr_valid || o_rd_req_valid) && c < 4000) begin
      @(posedge clk);
      c++;
    end
    repeat (4) @(posedge clk);
    chk({tag, "_drained"}, (c < 4000), 1);
    chk({tag, "_unsup"}, obs_unsup, exp_unsup);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  f;
    logic [9:0]  ln;
    logic [31:0] lo;
    int hl, n, c;

    // Reset state
    #12;
    chk("rst_wr_valid", o_wr_valid, 0);
    chk("rst_rd_valid", o_rd_req_valid, 0);
    chk("rst_np_ok", o_rx_np_ok, 1);
    chk("rst_tready", o_rx_tready, 0);
    chk("rst_unsup", o_unsup, 0);
    chk("rst_outs", {o_wr_addr, o_bar_hit, o_rd_len}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);

    send_tlp(2'b10, 5'd0, 0, 10'd2, 4'hF, 4'h3, 8'h01, 0, 32'h1000, 7'h01, 5, 32'hAA);
    wait_drain("mwr32");
    rd_pct = 15;
    send_tlp(2'b01, 5'd0, 0, 10'd0, 4'hF, 4'hF, 8'h12, 0, 32'h2000, 7'h01, 4, 0);
    wait_drain("mrd64_len0");
    rd_pct = 40;
    send_tlp(2'b10, 5'd0, 0, 10'd1, 4'hF, 4'h0, 8'h02, 0, 32'h3000, 7'h02, 4, 0);
    wait_drain("bar_miss");
`ifdef PCIE_RX_TLP_STATS_EN
    chk("stat_drop", o_drop_count, 1);
    chk("stat_tlp", o_tlp_count, 2);
`endif
    send_tlp(2'b10, 5'b01010, 0, 10'd3, 4'hF, 4'hF, 8'h03, 0, 32'h0, 7'h01, 6, 0);
    wait_drain("cpl_drop");
    wr_mode = 1;
    send_tlp(2'b10, 5'd0, 0, 10'd4, 4'h7, 4'hE, 8'h04, 0, 32'h4000, 7'h01, 5, 0);
    wait_drain("short_wr");
    wr_mode = 0;
    send_tlp(2'b11, 5'd0, 0, 10'd2, 4'hC, 4'h1, 8'h05, 0, 32'h5000, 7'h01, 8, 0);
    wait_drain("long_wr");
    send_tlp(2'b10, 5'd0, 1, 10'd1, 4'hF, 4'h0, 8'h06, 0, 32'h6000, 7'h01, 4, 0);
    send_tlp(2'b01, 5'd0, 0, 10'd1, 4'hF, 4'h0, 8'h07, 32'h1, 32'h7000, 7'h01, 4, 0);
    send_tlp(2'b10, 5'd0, 0, 10'd1, 4'hF, 4'h0, 8'h08, 0, 32'h8000, 7'h01, 3, 0);
    send_tlp(2'b00, 5'd0, 0, 10'd1, 4'hF, 4'h0, 8'h09, 0, 32'h9000, 7'h01, 5, 0);
    send_tlp(2'b00, 5'd0, 0, 10'd1, 4'hF, 4'h0, 8'h0A, 0, 32'hA000, 7'h01, 2, 0);
    send_tlp(2'b11, 5'd0, 0, 10'd4, 4'hF, 4'h3, 8'h0B, 0, 32'hFFFFFFF8, 7'h41, 8, 0);
    wait_drain("drops_wrap");

    // Random back-to-back traffic
    for (int t = 0; t < 80; t++) begin
      f  = 2'($urandom);
      hl = f[0] ? 4 : 3;
      ln = 10'($urandom_range(6, 1));
      if (!f[1] && $urandom_range(9) == 0) ln = 10'd0;
      lo = ($urandom_range(9) == 0) ? 32'hFFFFFFF4 : $urandom;
      if (f[1]) n = hl + int'(ln) + (($urandom_range(9) < 7) ? 0 : $urandom_range(4) - 2);
      else      n = ($urandom_range(9) < 8) ? hl : hl + $urandom_range(2) - 1;
      if (n < 1) n = 1;
      send_tlp(f, ($urandom_range(9) == 0) ? 5'b00100 : 5'd0, ($urandom_range(9) == 0),
               ln, 4'($urandom), 4'($urandom), 8'($urandom),
               ($urandom_range(19) == 0) ? 32'h10 : 32'h0, lo,
               ($urandom_range(9) < 8) ? (7'($urandom) | 7'h01) : (7'($urandom) & 7'h7E),
               n, 0);
    end
    wait_drain("random");

    // Reset in the middle of a write
    send_tlp(2'b10, 5'd0, 0, 10'd8, 4'hF, 4'hF, 8'h20, 0, 32'hB000, 7'h01, 11, 0);
    c = 0;
    while (exp_wr.size() > 5 && c < 500) begin @(posedge clk); c++; end
    chk("midwr_progress", (c < 500), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    drv_en = 1'b0;
    i_rx_tvalid = 1'b0;
    #1;
    chk("midrst_wr_valid", o_wr_valid, 0);
    chk("midrst_rd_valid", o_rd_req_valid, 0);
    chk("midrst_np_ok", o_rx_np_ok, 1);
    chk("midrst_tready", o_rx_tready, 0);
    txq.delete(); exp_wr.delete(); exp_rd.delete();
    exp_unsup = 0; obs_unsup = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; drv_en = 1'b1;
    repeat (3) @(posedge clk);
    send_tlp(2'b10, 5'd0, 0, 10'd3, 4'h8, 4'h1, 8'h21, 0, 32'hC000, 7'h01, 6, 32'h100);
    send_tlp(2'b00, 5'd0, 0, 10'd5, 4'hF, 4'hF, 8'h22, 0, 32'hD004, 7'h01, 3, 0);
    wait_drain("post_reset");
`ifdef PCIE_RX_TLP_STATS_EN
    chk("stat_tlp_after_rst", o_tlp_count, 2);
    chk("stat_drop_after_rst", o_drop_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
